// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared VGA timing constants, frame-buffer geometry defaults and the types
//   used by the frame-buffer arbiter and its address helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

    // 640x480 @ 60 Hz raster: total and visible counts per axis
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Frame-buffer geometry defaults (quarter resolution in each axis)
    localparam int FB_W_DEFAULT   = 160;
    localparam int FB_H_DEFAULT   = 120;
    localparam int DATA_W_DEFAULT = 4;
    localparam int ADDR_W_DEFAULT = 15;

    // How far ahead of the beam the display read is issued: one cycle for the
    // RAM access and one for the capture register.
    localparam int LOOKAHEAD = 2;

    typedef logic [DATA_W_DEFAULT-1:0] pixel_t;
    typedef logic [ADDR_W_DEFAULT-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISP_RD = 2'd1,
        HOST_WR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// -----------------------------------------------------------------------------
// fb_addr_calc
//   Combinational frame-buffer address: addr = row * 160 + col, built from two
//   shifts and adds so no multiplier is needed. The shift pair is tied to a
//   160-pixel-wide frame buffer.
//   Ports:
//     row  in  7       frame-buffer row
//     col  in  8       frame-buffer column
//     addr out ADDR_W  linear RAM address
// -----------------------------------------------------------------------------
module fb_addr_calc
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [6:0]        row,
    input  logic [7:0]        col,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] col_ext;

    assign row_ext = ADDR_W'(row);
    assign col_ext = ADDR_W'(col);

    // 160 = 128 + 32
    assign addr = (row_ext << 7) + (row_ext << 5) + col_ext;

endmodule

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
//   Shares a single-port frame-buffer RAM between VGA scan-out reads and a
//   one-entry buffered host write port. Display reads are issued two pixels
//   ahead of the beam on every fourth pixel of the visible area and always win;
//   the buffered host write is committed in any other cycle.
//   Ports:
//     vgaclk     in  1       pixel clock
//     reset      in  1       synchronous, active-high
//     vgaX       in  10      current horizontal count 0..799
//     vgaY       in  10      current vertical count 0..524
//     wr_valid   in  1       host write request
//     wr_ready   out 1       host write accepted when high with wr_valid
//     wr_x       in  8       frame-buffer column of the host write
//     wr_y       in  7       frame-buffer row of the host write
//     wr_data    in  DATA_W  host colour
//     mem_addr   out ADDR_W  RAM address
//     mem_we     out 1       RAM write enable
//     mem_wdata  out DATA_W  RAM write data
//     mem_rdata  in  DATA_W  RAM read data, one cycle after the address
//     pix_data   out DATA_W  colour for the current (vgaX, vgaY)
//     drop_count out 8       saturating count of out-of-range host writes
// -----------------------------------------------------------------------------
module fb_arbiter
    import vga_pkg::*;
#(
    parameter int FB_W   = FB_W_DEFAULT,
    parameter int FB_H   = FB_H_DEFAULT,
    parameter int SCALE  = 4,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              vgaclk,
    input  logic              reset,
    input  logic [9:0]        vgaX,
    input  logic [9:0]        vgaY,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_x,
    input  logic [6:0]        wr_y,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic [7:0]        drop_count
);

    localparam int SCALE_SH = $clog2(SCALE);

    // -------------------------------------------------------------------------
    // Look-ahead beam position
    // -------------------------------------------------------------------------
    logic [10:0] x_sum;
    logic [9:0]  nx;
    logic [9:0]  ny;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        x_sum = {1'b0, vgaX} + 11'(LOOKAHEAD);
        nx    = x_sum[9:0];
        ny    = vgaY;
        if (x_sum >= 11'(H_TOTAL)) begin
            nx = 10'(x_sum - 11'(H_TOTAL));
            ny = (vgaY == 10'(V_TOTAL - 1)) ? 10'd0 : vgaY + 10'd1;
        end
    end

    logic disp_slot;
    assign disp_slot = (nx < 10'(H_ACTIVE)) && (ny < 10'(V_ACTIVE)) &&
                       ((nx & 10'(SCALE - 1)) == 10'd0);

    // -------------------------------------------------------------------------
    // Address generation: one calculator per requester
    // -------------------------------------------------------------------------
    logic [6:0]        disp_row;
    logic [7:0]        disp_col;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] host_addr;

    assign disp_row = 7'(ny >> SCALE_SH);
    assign disp_col = 8'(nx >> SCALE_SH);

    logic              buf_full;
    logic [7:0]        buf_x;
    logic [6:0]        buf_y;
    logic [DATA_W-1:0] buf_data;

    fb_addr_calc #(.ADDR_W(ADDR_W)) u_disp_addr (
        .row  (disp_row),
        .col  (disp_col),
        .addr (disp_addr)
    );

    fb_addr_calc #(.ADDR_W(ADDR_W)) u_host_addr (
        .row  (buf_y),
        .col  (buf_x),
        .addr (host_addr)
    );

    // -------------------------------------------------------------------------
    // Host handshake
    // -------------------------------------------------------------------------
    logic accept;
    logic in_range;

    assign wr_ready = !buf_full && !reset;
    assign accept   = wr_valid && wr_ready;
    assign in_range = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);

    // -------------------------------------------------------------------------
    // Slot decision: display first, then a pending host write
    // -------------------------------------------------------------------------
    arb_state_t state;
    arb_state_t next_state;

    always_comb begin
        next_state = IDLE;
        if (disp_slot) begin
            next_state = DISP_RD;
        end else if (buf_full) begin
            next_state = HOST_WR;
        end
    end

    // RAM port is driven straight from this cycle's decision so the read for
    // column c is on the bus at vgaX = 4c-2; idle cycles repeat the last
    // address and data so the RAM pins do not toggle needlessly.
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_wdata;

    always_comb begin
        mem_addr  = last_addr;
        mem_we    = 1'b0;
        mem_wdata = last_wdata;
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (next_state == DISP_RD) begin
            mem_addr = disp_addr;
        end else if (next_state == HOST_WR) begin
            mem_addr  = host_addr;
            mem_we    = 1'b1;
            mem_wdata = buf_data;
        end
    end

    // -------------------------------------------------------------------------
    // State, write buffer, pixel hold and drop counter
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] pix_hold;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            state      <= IDLE;
            buf_full   <= 1'b0;
            // NOTE: the buffer payload is reset along with its valid flag so
            // the host address path never presents X to the RAM bus.
            buf_x      <= '0;
            buf_y      <= '0;
            buf_data   <= '0;
            pix_hold   <= '0;
            drop_count <= '0;
            last_addr  <= '0;
            last_wdata <= '0;
        end else begin
            state      <= next_state;
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;

            // state == DISP_RD marks the cycle in which the RAM returns the
            // word addressed in the previous cycle.
            if (state == DISP_RD) begin
                pix_hold <= mem_rdata;
            end

            // Accept and commit are mutually exclusive: accept needs an empty
            // buffer, commit needs a full one.
            if (next_state == HOST_WR) begin
                buf_full <= 1'b0;
            end

            if (accept) begin
                if (in_range) begin
                    buf_full <= 1'b1;
                    buf_x    <= wr_x;
                    buf_y    <= wr_y;
                    buf_data <= wr_data;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

    assign pix_data = (!reset && (vgaX < 10'(H_ACTIVE)) && (vgaY < 10'(V_ACTIVE)))
                      ? pix_hold : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
//   Self-checking bench for fb_arbiter: behavioural single-port RAM with a
//   one-cycle read, a procedural beam position, and a queue of expected RAM
//   writes checked whenever the DUT asserts mem_we.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;

    logic        clk;
    logic        reset;
    logic [9:0]  vgaX;
    logic [9:0]  vgaY;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [3:0]  wr_data;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;
    logic [3:0]  pix_data;
    logic [7:0]  drop_count;

    fb_arbiter dut (
        .vgaclk     (clk),
        .reset      (reset),
        .vgaX       (vgaX),
        .vgaY       (vgaY),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_data   (pix_data),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM with a bench-side preload port
    logic [3:0]  ram [0:32767];
    logic        pre_we;
    logic [14:0] pre_addr;
    logic [3:0]  pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int tests_run    = 0;
    int tests_failed = 0;
    int commits      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [14:0] addr;
        logic [3:0]  data;
    } wr_exp_t;

    wr_exp_t exp_q[$];

    // Write scoreboard: every RAM write must match the oldest expected write
    initial begin
        forever begin
            @(negedge clk);
            if (mem_we !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", {31'b0, mem_we}, 32'd0);
                end else begin
                    wr_exp_t e;
                    e = exp_q.pop_front();
                    check("we_addr", {17'b0, mem_addr}, {17'b0, e.addr});
                    check("we_data", {28'b0, mem_wdata}, {28'b0, e.data});
                    commits++;
                end
            end
        end
    end

    // Advance one clock and present a new beam position
    task automatic at(input int x, input int y);
        @(posedge clk);
        #1;
        vgaX = 10'(x);
        vgaY = 10'(y);
    endtask

    initial begin
        int pre_a [4] = '{161, 162, 482, 483};
        int pre_d [4] = '{10, 5, 9, 6};
        int acc;

        reset    = 1'b1;
        vgaX     = 10'd700;
        vgaY     = 10'd500;
        wr_valid = 1'b0;
        wr_x     = '0;
        wr_y     = '0;
        wr_data  = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;

        // Reset, preloading the RAM meanwhile
        for (int i = 0; i < 4; i++) begin
            at(700 + i, 500);
            pre_we   = 1'b1;
            pre_addr = 15'(pre_a[i]);
            pre_data = 4'(pre_d[i]);
            @(negedge clk);
            check("rst_ready", {31'b0, wr_ready}, 32'd0);
            check("rst_we", {31'b0, mem_we}, 32'd0);
            check("rst_addr", {17'b0, mem_addr}, 32'd0);
        end
        at(704, 500);
        pre_we = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, wr_ready}, 32'd1);
        check("post_rst_addr", {17'b0, mem_addr}, 32'd0);
        check("post_rst_wdata", {28'b0, mem_wdata}, 32'd0);
        check("post_rst_pix", {28'b0, pix_data}, 32'd0);
        check("post_rst_drop", {24'b0, drop_count}, 32'd0);

        // Display fetch along line 4 (frame-buffer row 1)
        for (int x = 0; x < 800; x++) begin
            at(x, 4);
            @(negedge clk);
            if (x == 2) begin
                check("disp_addr_c1", {17'b0, mem_addr}, 32'd161);
                check("disp_we_c1", {31'b0, mem_we}, 32'd0);
            end
            if (x >= 4 && x <= 7) check("disp_pix_c1", {28'b0, pix_data}, 32'hA);
            if (x == 8) check("disp_pix_c2", {28'b0, pix_data}, 32'h5);
            if (x == 634) check("disp_addr_c159", {17'b0, mem_addr}, 32'd319);
            if (x == 700) check("disp_pix_hblank", {28'b0, pix_data}, 32'd0);
        end

        // Line and frame wrap of the look-ahead
        at(798, 7);
        @(negedge clk);
        check("wrap_line_addr", {17'b0, mem_addr}, 32'd320);
        at(799, 7);
        @(negedge clk);
        check("hold_addr", {17'b0, mem_addr}, 32'd320);
        check("hold_we", {31'b0, mem_we}, 32'd0);
        at(798, 479);
        @(negedge clk);
        check("vblank_hold_addr", {17'b0, mem_addr}, 32'd320);
        at(798, 524);
        @(negedge clk);
        check("wrap_frame_addr", {17'b0, mem_addr}, 32'd0);

        // Collision: write accepted just before a display slot
        at(4, 12);
        at(5, 12);
        wr_valid = 1'b1;
        wr_x     = 8'd5;
        wr_y     = 7'd3;
        wr_data  = 4'h7;
        exp_q.push_back('{addr: 15'd485, data: 4'h7});
        @(negedge clk);
        check("coll_ready", {31'b0, wr_ready}, 32'd1);
        at(6, 12);
        wr_valid = 1'b0;
        @(negedge clk);
        check("coll_disp_we", {31'b0, mem_we}, 32'd0);
        check("coll_disp_addr", {17'b0, mem_addr}, 32'd482);
        at(7, 12);
        @(negedge clk);
        check("coll_we", {31'b0, mem_we}, 32'd1);
        check("coll_addr", {17'b0, mem_addr}, 32'd485);
        at(8, 12);
        @(negedge clk);
        check("coll_pix", {28'b0, pix_data}, 32'h9);
        check("coll_we_done", {31'b0, mem_we}, 32'd0);

        // Reset while a write is pending
        at(9, 12);
        at(10, 12);
        @(negedge clk);
        check("rmid_fetch_addr", {17'b0, mem_addr}, 32'd483);
        at(11, 12);
        at(12, 12);
        wr_valid = 1'b1;
        wr_x     = 8'd1;
        wr_y     = 7'd1;
        wr_data  = 4'hF;
        @(negedge clk);
        check("rmid_pix_before", {28'b0, pix_data}, 32'h6);
        check("rmid_ready", {31'b0, wr_ready}, 32'd1);
        at(13, 12);
        wr_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("rmid_we", {31'b0, mem_we}, 32'd0);
        check("rmid_ready_in_rst", {31'b0, wr_ready}, 32'd0);
        check("rmid_pix_in_rst", {28'b0, pix_data}, 32'd0);
        at(14, 12);
        reset = 1'b0;
        @(negedge clk);
        check("rmid_ready_after", {31'b0, wr_ready}, 32'd1);
        check("rmid_pix_after", {28'b0, pix_data}, 32'd0);
        check("rmid_disp_addr", {17'b0, mem_addr}, 32'd484);
        at(15, 12);
        @(negedge clk);
        check("rmid_no_commit", {31'b0, mem_we}, 32'd0);
        at(16, 12);
        @(negedge clk);
        check("rmid_ram_intact", {28'b0, ram[161]}, 32'hA);

        // Back-to-back writes during vertical blanking
        acc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            at(cyc, 500);
            wr_valid = (acc < 10);
            wr_x     = 8'(10 + acc);
            wr_y     = 7'd20;
            wr_data  = 4'(acc + 1);
            @(negedge clk);
            check("bb_ready", {31'b0, wr_ready}, {31'b0, ((cyc % 2) == 0)});
            if (wr_valid && wr_ready) begin
                exp_q.push_back('{addr: 15'(3210 + acc), data: 4'(acc + 1)});
                acc++;
            end
        end
        at(20, 500);
        wr_valid = 1'b0;
        at(21, 500);
        @(negedge clk);
        check("bb_accepted", 32'(acc), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check("bb_ram", {28'b0, ram[3210 + i]}, 32'(i + 1));
        end

        // Out-of-range writes are accepted, dropped and counted
        at(30, 500);
        wr_valid = 1'b1;
        wr_x     = 8'd160;
        wr_y     = 7'd0;
        wr_data  = 4'h3;
        @(negedge clk);
        check("oor_ready", {31'b0, wr_ready}, 32'd1);
        check("oor_drop0", {24'b0, drop_count}, 32'd0);
        at(31, 500);
        wr_valid = 1'b0;
        @(negedge clk);
        check("oor_drop1", {24'b0, drop_count}, 32'd1);
        check("oor_ready_after", {31'b0, wr_ready}, 32'd1);
        check("oor_no_we", {31'b0, mem_we}, 32'd0);
        for (int j = 0; j < 299; j++) begin
            at(32 + j, 500);
            wr_valid = 1'b1;
            wr_x     = 8'd0;
            wr_y     = 7'd120;
            @(negedge clk);
            if (j == 253) check("oor_drop254", {24'b0, drop_count}, 32'd254);
            if (j == 254) check("oor_drop255", {24'b0, drop_count}, 32'd255);
        end
        at(400, 500);
        wr_valid = 1'b0;
        @(negedge clk);
        check("oor_saturated", {24'b0, drop_count}, 32'd255);

        at(401, 500);
        @(negedge clk);
        check("wq_empty", 32'(exp_q.size()), 32'd0);
        check("commit_count", 32'(commits), 32'd11);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
